// File: rtl/gldp_decoder_if.sv
// Pixel stream, accumulator RAM and gray-level result signals of the GLDP decoder.
// The decoder takes the slave side; the pixel source, RAM and sink take the master side.
interface gldp_decoder_if #(
  parameter int ADDR_W = 17
);
  logic              flm;
  logic              pix_valid;
  logic              pix_bit;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [9:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [9:0]        mem_wr_data;
  logic              gray_valid;
  logic [4:0]        gray_out;
  logic [ADDR_W-1:0] gray_addr;
  logic              locked;
  logic              overrun;

  modport slave (
    input  flm, pix_valid, pix_bit, mem_rd_data,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output gray_valid, gray_out, gray_addr, locked, overrun
  );

  modport master (
    output flm, pix_valid, pix_bit, mem_rd_data,
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  gray_valid, gray_out, gray_addr, locked, overrun
  );
endinterface

// File: rtl/gldp_decoder.sv
// GLDP temporal decoder: counts the ones in each pixel's 1-bit stream over a 31-frame
// window through an external accumulator RAM and reports the recovered 5-bit level.
module gldp_decoder #(
  parameter int NPIX   = 76800,
  parameter int ADDR_W = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  gldp_decoder_if.slave bus
);

  localparam logic [ADDR_W:0] C_NPIX    = (ADDR_W+1)'(NPIX);
  localparam logic [4:0]      C_FC_LAST = 5'd30;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            r_state;
  logic [4:0]        r_fc;
  logic [ADDR_W:0]   r_pix_cnt;
  logic              r_locked;
  logic              r_overrun;

  logic              r_s1_valid;
  logic              r_s1_bit;
  logic              r_s1_first;
  logic              r_s1_last;
  logic [ADDR_W-1:0] r_s1_addr;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [9:0]        r_wr_data;
  logic              r_gray_valid;
  logic [4:0]        r_gray_out;
  logic [ADDR_W-1:0] r_gray_addr;

  logic              w_run;
  logic              w_accept;
  logic              w_in_range;
  logic              w_rd_en;
  logic [4:0]        w_fc;
  logic [ADDR_W:0]   w_idx;
  logic [4:0]        w_rd_cnt;
  logic [5:0]        w_cnt6;
  logic [4:0]        w_cnt;
  logic [4:0]        w_lvl;

  // A frame strobe takes effect before a pixel in the same cycle, so the pixel
  // sees the new frame counter and pixel index 0.
  always_comb begin
    w_run      = rst_n && ((r_state == S_RUN) || bus.flm);
    w_fc       = r_fc;
    w_idx      = r_pix_cnt;
    if (bus.flm) begin
      w_fc  = ((r_state == S_IDLE) || (r_fc == C_FC_LAST)) ? 5'd0 : r_fc + 5'd1;
      w_idx = '0;
    end
    w_accept   = w_run && bus.pix_valid;
    w_in_range = (w_idx < C_NPIX);
    w_rd_en    = w_accept && w_in_range;
  end

  always_comb begin
    w_rd_cnt = r_s1_first ? 5'd0 : bus.mem_rd_data[4:0];
    w_cnt6   = {1'b0, w_rd_cnt} + {5'd0, r_s1_bit};
    w_cnt    = w_cnt6[4:0];
    w_lvl    = r_s1_last ? w_cnt : bus.mem_rd_data[9:5];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_fc      <= C_FC_LAST;
      r_pix_cnt <= '0;
      r_locked  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (bus.flm) begin
        if (r_state == S_IDLE) begin
          r_state <= S_RUN;
        end else if (r_fc == C_FC_LAST) begin
          r_locked <= 1'b1;
        end
        r_fc <= w_fc;
      end
      r_pix_cnt <= w_rd_en ? w_idx + {{ADDR_W{1'b0}}, 1'b1} : w_idx;
      if (w_accept && !w_in_range) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Frame position travels with each pixel so the pipeline drains cleanly across flm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_bit     <= 1'b0;
      r_s1_first   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_addr    <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_gray_valid <= 1'b0;
      r_gray_out   <= '0;
      r_gray_addr  <= '0;
    end else begin
      r_s1_valid   <= w_rd_en;
      r_s1_bit     <= bus.pix_bit;
      r_s1_first   <= (w_fc == 5'd0);
      r_s1_last    <= (w_fc == C_FC_LAST);
      r_s1_addr    <= w_idx[ADDR_W-1:0];
      r_wr_en      <= r_s1_valid;
      r_wr_addr    <= r_s1_valid ? r_s1_addr : '0;
      r_wr_data    <= r_s1_valid ? {w_lvl, w_cnt} : '0;
      r_gray_valid <= r_s1_valid;
      r_gray_addr  <= r_s1_valid ? r_s1_addr : '0;
      r_gray_out   <= (r_s1_valid && (r_locked || r_s1_last)) ? w_lvl : '0;
    end
  end

  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_rd_addr = w_rd_en ? w_idx[ADDR_W-1:0] : '0;
  assign bus.mem_wr_en   = r_wr_en;
  assign bus.mem_wr_addr = r_wr_addr;
  assign bus.mem_wr_data = r_wr_data;
  assign bus.gray_valid  = r_gray_valid;
  assign bus.gray_out    = r_gray_out;
  assign bus.gray_addr   = r_gray_addr;
  assign bus.locked      = r_locked;
  assign bus.overrun     = r_overrun;

  // One increment per frame over 31 frames keeps the count within 5 bits.
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) r_s1_valid |-> !w_cnt6[5]);

endmodule
